alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the core's single ALU between two requesters: port 0 (execute stage) and port 1 (atomic/AMO unit). Each port has a valid/ready request channel carrying ALU control lines and two operands, and a registered valid/ready response channel. The block grants one request per cycle, drives the shared ALU combinationally, and captures the result into that port's response register. A lock lets port 1 hold the ALU across a read-modify-write sequence.

## Interface
- `DATA_WIDTH`, 32: operand/result width.
- `OP_WIDTH`, 4: ALU control-line width, the same encoding as `ALU_*` in `alu_defines.vh`.

Ports:
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  reset, synchronous, active-low.
- `i_req0_valid` / `o_req0_ready`  in/out  1  port-0 request handshake.
- `i_req0_op`  in  OP_WIDTH  port-0 ALU control lines.
- `i_req0_a`, `i_req0_b`  in  DATA_WIDTH  port-0 operands.
- `o_rsp0_valid` / `i_rsp0_ready`  out/in  1  port-0 response handshake.
- `o_rsp0_result`  out  DATA_WIDTH  port-0 result.
- `o_rsp0_zero`  out  1  port-0 zero flag.
- `i_req1_*`, `o_req1_ready`, `o_rsp1_*`, `i_rsp1_ready`: identical set for port 1.
- `i_req1_lock`  in  1  keep the grant on port 1 after this request.
- `o_alu_op`  out  OP_WIDTH  to ALU control lines.
- `o_alu_a`, `o_alu_b`  out  DATA_WIDTH  to ALU operands.
- `i_alu_result`  in  DATA_WIDTH  ALU output; combinational, same cycle.
- `i_alu_zero`  in  1  ALU zero flag.

## Operation
- Per-port response slot: EMPTY or FULL.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `rsp_valid & rsp_ready` with no new accept.
  - FULL→FULL when a drain and an accept happen in the same cycle; the slot loads the new result.
- Eligible(p) = `req_valid(p)` & (slot(p) EMPTY | `rsp_ready(p)`).
- Grant:
  - Exactly one eligible port is granted per cycle.
  - `o_reqN_ready` = grant(N) & slot condition above.
  - Ready never depends on the same port's `req_valid`, and is 0 for the ungranted port.
- Lock FSM has two states, UNLOCKED and LOCKED1.
  - UNLOCKED→LOCKED1 when port 1 is accepted with `i_req1_lock`=1.
  - LOCKED1→UNLOCKED when port 1 is accepted with `i_req1_lock`=0.
  - In LOCKED1 only port 1 may be granted. Port 0 stalls even if eligible.
- ALU drive:
  - On accept, `o_alu_*` = the granted request's fields.
  - With no accept: `o_alu_op`=`ALU_ADD` and `o_alu_a`=`o_alu_b`=0, a deterministic idle value.
- Capture: on accept, the slot registers `i_alu_result` and `i_alu_zero`.
- Op codes are not interpreted. Unknown codes pass through unchanged.

## Timing
- Reset (`i_rstn`=0 at a clock edge):
  - Both slots become EMPTY.
  - Lock state becomes UNLOCKED.
  - Round-robin pointer points to port 0.
  - `o_rsp*_valid`=0, `o_rsp*_result`=0, `o_rsp*_zero`=0.
- Reset mid-lock or with FULL slots discards all of that state. Requests asserted during reset are not accepted.
- Latency is 1 cycle: the response is valid the cycle after accept.
- Throughput is 1 accept per cycle in total, and 1 per cycle per port when the response is drained each cycle.
- Once asserted, response valid, result and zero stay stable until `rsp_ready`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin.
  - When both ports are eligible in UNLOCKED, grant the port not granted last.
  - The pointer updates only on accept.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 over port 1. The lock behaves identically in both builds.

## Structure
- Package `alu_arb_pkg` contains:
  - `port_e` enum: PORT0, PORT1.
  - `lock_state_e` enum: UNLOCKED, LOCKED1.
  - `slot_state_e` enum: EMPTY, FULL.
  - `alu_req_t` struct: op, a, b.
  - `alu_rsp_t` struct: result, zero.
- Sub-module `alu_arb_rsp_slot` is one response register with valid/ready; it is instantiated twice.

## Test plan
- Port 0 only: op=`ALU_ADD`, a=5, b=7, `rsp0_ready`=1.
  - `o_alu_a`=5 in the accept cycle.
  - `o_rsp0_result`=12 and `o_rsp0_zero`=0 the next cycle.
- Both ports request every cycle for 4 cycles, both `rsp_ready`=1:
  - RR build: grants alternate 0,1,0,1.
  - Fixed-priority build: port 0 is granted 4 times and port 1 is never ready.
- Back-pressure: `rsp1_ready`=0 with a port-1 response FULL. A new port-1 request stays not-ready until `rsp1_ready`=1. Once it rises, accept and drain happen in the same cycle and `o_rsp1_valid` stays 1 with the new result.
- Lock: port 1 is accepted with lock=1 (SUB a=3, b=3, zero=1), port 0 requests for 3 cycles, then port 1 is accepted with lock=0.
  - Port 0 ready=0 for the whole interval.
  - Port 0 is granted the cycle after the unlock.
- Reset mid-operation: `i_rstn`=0 for 1 cycle while LOCKED1 with both slots FULL.
  - Next cycle: both `rsp_valid`=0 and the lock is clear.
  - A port-0 request is accepted immediately.
- Idle: no requests for 3 cycles. `o_alu_op`=`ALU_ADD`, operands 0, no `rsp_valid`.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and ALU op codes for the ALU arbiter.
package alu_arb_pkg;
    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
    typedef enum logic {PORT0, PORT1} port_e;
    typedef enum logic {UNLOCKED, LOCKED1} lock_state_e;
    typedef enum logic {EMPTY, FULL} slot_state_e;
    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } alu_req_t;
    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
    } alu_rsp_t;
endpackage

// File: rtl/alu_arb_rsp_slot.sv
// alu_arb_rsp_slot: one registered response slot with valid/ready drain.
import alu_arb_pkg::*;
module alu_arb_rsp_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] next_result,
    input  logic                  next_zero,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  free
);
    slot_state_e state;
    assign valid = state == FULL;
    // The slot can take a new result while its current one drains.
    assign free = state == EMPTY || ready;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= EMPTY;
            result <= '0;
            zero   <= 1'b0;
        end else if (load) begin
            state  <= FULL;
            result <= next_result;
            zero   <= next_zero;
        end else if (ready) begin
            state  <= EMPTY;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between execute (port 0) and AMO (port 1) requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
import alu_arb_pkg::*;
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [OP_WIDTH-1:0]   i_req0_op,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic [DATA_WIDTH-1:0] o_rsp0_result,
    output logic                  o_rsp0_zero,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [OP_WIDTH-1:0]   i_req1_op,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    input  logic                  i_req1_lock,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp1_result,
    output logic                  o_rsp1_zero,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_alu_zero
);
    logic free0, free1, elig0, grant0, grant1, acc0, acc1;
    lock_state_e lock_q;
`ifdef ALU_ARB_RR_EN
    logic elig1;
    port_e ptr_q;
`endif
    // Grants are formed from the other port's eligibility only, so ready never
    // depends on the same port's valid.
    always_comb begin
        elig0 = i_req0_valid & free0;
`ifdef ALU_ARB_RR_EN
        elig1 = i_req1_valid & free1;
        grant0 = lock_q == UNLOCKED && (ptr_q == PORT0 || !elig1);
        grant1 = lock_q == LOCKED1 || ptr_q == PORT1 || !elig0;
`else
        grant0 = lock_q == UNLOCKED;
        grant1 = lock_q == LOCKED1 || !elig0;
`endif
        o_req0_ready = grant0 & free0;
        o_req1_ready = grant1 & free1;
        acc0 = grant0 & free0 & i_req0_valid;
        acc1 = grant1 & free1 & i_req1_valid & !acc0;
        o_alu_op = acc0 ? i_req0_op : acc1 ? i_req1_op : OP_WIDTH'(ALU_ADD);
        o_alu_a = acc0 ? i_req0_a : acc1 ? i_req1_a : '0;
        o_alu_b = acc0 ? i_req0_b : acc1 ? i_req1_b : '0;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            lock_q <= UNLOCKED;
        else if (acc1)
            lock_q <= i_req1_lock ? LOCKED1 : UNLOCKED;
    end
`ifdef ALU_ARB_RR_EN
    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            ptr_q <= PORT0;
        else if (acc0 | acc1)
            ptr_q <= acc0 ? PORT1 : PORT0;
    end
`endif
    alu_arb_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot0 (
        .clk(i_clk), .rstn(i_rstn), .load(acc0),
        .next_result(i_alu_result), .next_zero(i_alu_zero), .ready(i_rsp0_ready),
        .valid(o_rsp0_valid), .result(o_rsp0_result), .zero(o_rsp0_zero), .free(free0)
    );
    alu_arb_rsp_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot1 (
        .clk(i_clk), .rstn(i_rstn), .load(acc1),
        .next_result(i_alu_result), .next_zero(i_alu_zero), .ready(i_rsp1_ready),
        .valid(o_rsp1_valid), .result(o_rsp1_result), .zero(o_rsp1_zero), .free(free1)
    );
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a port-level reference model.
module tb_alu_arbiter;
    import alu_arb_pkg::*;
    localparam int DW = ALU_DATA_W;
    localparam int OW = ALU_OP_W;

    logic i_clk = 1'b0;
    logic i_rstn = 1'b0;
    logic o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_rsp0_zero, o_rsp1_zero;
    logic [DW-1:0] o_rsp0_result, o_rsp1_result, o_alu_a, o_alu_b, i_alu_result;
    logic [OW-1:0] o_alu_op;
    logic i_alu_zero;

    bit v[2];
    bit rr[2];
    bit lk;
    alu_req_t req[2];

    bit full_m[2];
    logic [DW-1:0] res_m[2];
    bit zero_m[2];
    bit locked_m;
    int last_m;
    bit obs_acc0, obs_acc1, obs_rdy0;
    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    function automatic logic [DW-1:0] alu_fn(logic [OW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        return op == ALU_ADD ? a + b : op == ALU_SUB ? a - b : a ^ b;
    endfunction

    assign i_alu_result = alu_fn(o_alu_op, o_alu_a, o_alu_b);
    assign i_alu_zero = i_alu_result == '0;

    alu_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_req0_valid(v[0]), .o_req0_ready(o_req0_ready),
        .i_req0_op(req[0].op), .i_req0_a(req[0].a), .i_req0_b(req[0].b),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(rr[0]),
        .o_rsp0_result(o_rsp0_result), .o_rsp0_zero(o_rsp0_zero),
        .i_req1_valid(v[1]), .o_req1_ready(o_req1_ready),
        .i_req1_op(req[1].op), .i_req1_a(req[1].a), .i_req1_b(req[1].b),
        .i_req1_lock(lk),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(rr[1]),
        .o_rsp1_result(o_rsp1_result), .o_rsp1_zero(o_rsp1_zero),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero)
    );

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp();
        check("rsp0_valid", o_rsp0_valid, full_m[0]);
        check("rsp0_result", o_rsp0_result, res_m[0]);
        check("rsp0_zero", o_rsp0_zero, zero_m[0]);
        check("rsp1_valid", o_rsp1_valid, full_m[1]);
        check("rsp1_result", o_rsp1_result, res_m[1]);
        check("rsp1_zero", o_rsp1_zero, zero_m[1]);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        for (int p = 0; p < 2; p++) begin
            full_m[p] = 0;
            res_m[p] = '0;
            zero_m[p] = 0;
        end
        locked_m = 0;
        last_m = 1;
        check_rsp();
    endtask

    // A port is ready when it could take a result and would win if it requested.
    task automatic cycle();
        bit open0, open1, rdy0, rdy1, acc0, acc1;
        alu_req_t ex;
        open0 = !full_m[0] || rr[0];
        open1 = !full_m[1] || rr[1];
`ifdef ALU_ARB_RR_EN
        rdy0 = open0 && !locked_m && (!(v[1] && open1) || last_m == 1);
        rdy1 = open1 && (locked_m || !(v[0] && open0) || last_m == 0);
`else
        rdy0 = open0 && !locked_m;
        rdy1 = open1 && (locked_m || !(v[0] && open0));
`endif
        acc0 = v[0] && rdy0;
        acc1 = v[1] && rdy1 && !acc0;
        ex = acc0 ? req[0] : acc1 ? req[1] : alu_req_t'{ALU_ADD, '0, '0};
        #2;
        obs_acc0 = o_req0_ready && v[0];
        obs_acc1 = o_req1_ready && v[1];
        obs_rdy0 = o_req0_ready;
        check("req0_ready", o_req0_ready, rdy0);
        check("req1_ready", o_req1_ready, rdy1);
        check("alu_op", o_alu_op, ex.op);
        check("alu_a", o_alu_a, ex.a);
        check("alu_b", o_alu_b, ex.b);
        @(posedge i_clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (p == 0 ? acc0 : acc1) begin
                full_m[p] = 1;
                res_m[p] = alu_fn(req[p].op, req[p].a, req[p].b);
                zero_m[p] = res_m[p] == '0;
            end else if (rr[p]) begin
                full_m[p] = 0;
            end
        end
        if (acc1) locked_m = lk;
`ifdef ALU_ARB_RR_EN
        if (acc0) last_m = 0;
        if (acc1) last_m = 1;
`endif
        check_rsp();
    endtask

    initial begin
        logic [3:0] seq;
        bit any_rdy0;
        req[0] = '0;
        req[1] = '0;
        do_reset();

        // Port 0 alone: 5 + 7
        v[0] = 1; req[0] = alu_req_t'{ALU_ADD, 32'd5, 32'd7}; rr[0] = 1;
        cycle();
        check("t1_result", o_rsp0_result, 32'd12);
        check("t1_zero", o_rsp0_zero, 1'b0);
        v[0] = 0;
        cycle();

        // Both ports requesting for four cycles
        do_reset();
        v[0] = 1; v[1] = 1; rr[0] = 1; rr[1] = 1;
        req[0] = alu_req_t'{ALU_ADD, 32'd10, 32'd1};
        req[1] = alu_req_t'{ALU_SUB, 32'd10, 32'd1};
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = obs_acc1;
        end
`ifdef ALU_ARB_RR_EN
        check("t2_grant_seq", seq, 4'b1010);
`else
        check("t2_grant_seq", seq, 4'b0000);
`endif

        // Port-1 back-pressure
        v[0] = 0; v[1] = 1; rr[1] = 0;
        req[1] = alu_req_t'{ALU_ADD, 32'd1, 32'd2};
        cycle();
        req[1] = alu_req_t'{ALU_SUB, 32'd10, 32'd4};
        repeat (2) cycle();
        rr[1] = 1;
        cycle();
        check("t3_valid", o_rsp1_valid, 1'b1);
        check("t3_result", o_rsp1_result, 32'd6);
        v[1] = 0;
        cycle();

        // Lock held by port 1 across a read-modify-write
        v[1] = 1; lk = 1; req[1] = alu_req_t'{ALU_SUB, 32'd3, 32'd3};
        cycle();
        check("t4_zero", o_rsp1_zero, 1'b1);
        any_rdy0 = 0;
        v[1] = 0; v[0] = 1; req[0] = alu_req_t'{ALU_ADD, 32'd1, 32'd1};
        for (int i = 0; i < 3; i++) begin
            cycle();
            any_rdy0 |= obs_rdy0;
        end
        v[1] = 1; lk = 0; req[1] = alu_req_t'{ALU_ADD, 32'd2, 32'd2};
        cycle();
        any_rdy0 |= obs_rdy0;
        check("t4_port0_stalled", any_rdy0, 1'b0);
        v[1] = 0;
        cycle();
        check("t4_port0_after_unlock", obs_acc0, 1'b1);

        // Reset while locked with both slots full
        v[0] = 1; rr[0] = 1; req[0] = alu_req_t'{ALU_ADD, 32'd4, 32'd4};
        cycle();
        v[0] = 0; rr[0] = 0; v[1] = 1; lk = 1; rr[1] = 1;
        cycle();
        v[0] = 1; rr[1] = 0;
        do_reset();
        v[1] = 0; lk = 0; rr[0] = 1;
        cycle();
        check("t5_accept_after_reset", obs_acc0, 1'b1);

        // Idle
        v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
        repeat (3) cycle();
        check("t6_rsp0_idle", o_rsp0_valid, 1'b0);
        check("t6_rsp1_idle", o_rsp1_valid, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                v[p] = $urandom_range(0, 1) == 1;
                rr[p] = $urandom_range(0, 2) != 0;
                req[p].op = OW'($urandom_range(0, 15));
                req[p].a = $urandom_range(0, 1) == 1 ? DW'($urandom) : DW'($urandom_range(0, 3));
                req[p].b = $urandom_range(0, 1) == 1 ? DW'($urandom) : DW'($urandom_range(0, 3));
            end
            lk = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 49) == 0)
                do_reset();
            else
                cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
